rw_access_ctrl: RTL and testbench
=================================

# rw_access_ctrl

Parametrised read/write access controller that sits between a single-requester chip-select interface and a simple memory or register-file port. It extends the basic IDLE/SETUP/WRITE/READ flow with captured address and data buses, a wait-state handshake from the target (`mem_ready`), read-data return, completion and error signalling, and address-range checking. It is the access-sequencing stage in front of on-chip register banks and SRAM wrappers.

## Interface
- `ADDR_W`, 8: address width.
- `DATA_W`, 32: data width.
- `ADDR_MAX`, 2**ADDR_W-1: highest legal address; higher addresses are rejected.
- `TIMEOUT_CYCLES`, 16: maximum ACCESS cycles without `mem_ready`. Used only with `RWAC_TIMEOUT_EN`; must be ≥1.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset_b`  in  1  asynchronous active-low reset.
- `cs`  in  1  request strobe / chip select.
- `write`  in  1  1 = write, 0 = read; sampled with `cs`.
- `addr`  in  ADDR_W  request address.
- `wdata`  in  DATA_W  write data.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  error qualifier; valid only with `done`.
- `rdata`  out  DATA_W  read data; holds its value until the next successful read.
- `wr_en`  out  1  target write strobe.
- `rd_en`  out  1  target read strobe.
- `mem_addr`  out  ADDR_W  captured address to target.
- `mem_wdata`  out  DATA_W  captured write data to target.
- `mem_rdata`  in  DATA_W  target read data, valid when `mem_ready`=1 during a read.
- `mem_ready`  in  1  target completion for the current access.

## Operation
- States: IDLE, SETUP, ACCESS, DONE. The 2-bit state register resets to IDLE.
- **IDLE:**
  - If `cs`=1, capture `write`, `addr` and `wdata` into `mem_addr`, `mem_wdata` and a write flag, then go to SETUP.
  - Otherwise remain in IDLE.
- **SETUP:**
  - If `cs`=0, abort and return to IDLE. No strobe is issued and no `done` is generated.
  - Else if `mem_addr` > `ADDR_MAX`, go to DONE with the error flag set.
  - Else go to ACCESS.
- **ACCESS:**
  - `wr_en`=write flag and `rd_en`=!write flag, held for every ACCESS cycle.
  - `cs` is ignored; the access cannot be aborted.
  - When `mem_ready`=1: go to DONE. On a read, load `rdata` from `mem_rdata` in that cycle.
  - Otherwise stay in ACCESS and increment the wait counter.
- **DONE:**
  - `done`=1 and `err`=error flag.
  - Next state is always IDLE. A `cs` asserted during DONE is not accepted; it must still be high in IDLE.
- Outputs decode from state (Moore). `wr_en` and `rd_en` are never high together and are 0 outside ACCESS.
- The error flag and wait counter clear on entry to SETUP.
- `rdata` is unchanged by writes, aborts and errors.

## Timing
- Reset values:
  - state IDLE.
  - `busy`, `done`, `err`, `wr_en`, `rd_en` all 0.
  - `rdata`, `mem_addr`, `mem_wdata` all 0.
- Reset asserted mid-access forces IDLE immediately. No `done` is issued for the interrupted access.
- Minimum latency, with `cs` sampled in IDLE at cycle N:
  - N+1: SETUP.
  - N+2: ACCESS with a strobe.
  - N+3: DONE, `done`=1, `rdata` valid if `mem_ready`=1 at N+2.
  - N+4: IDLE. The earliest next request is accepted at edge N+4; sustained throughput is one access per 4 cycles.
- Each cycle with `mem_ready`=0 in ACCESS adds one cycle to the latency.
- Address error: DONE with `err`=1 at N+2; no strobe is issued.

## Configuration
- `RWAC_TIMEOUT_EN` defined:
  - The wait counter is compiled in, with width $clog2(TIMEOUT_CYCLES+1).
  - If ACCESS has lasted `TIMEOUT_CYCLES` cycles with `mem_ready`=0 each cycle, go to DONE with `err`=1. The strobe drops and `rdata` is unchanged.
  - If `mem_ready`=1 in the final allowed cycle, the access completes normally; ready wins over timeout.
- `RWAC_TIMEOUT_EN` undefined:
  - No counter is built and ACCESS waits indefinitely for `mem_ready`.
  - `TIMEOUT_CYCLES` is ignored.

## Test plan
- Write, zero wait: `cs`=1, `write`=1, `addr`=0x10, `wdata`=0xDEADBEEF with `mem_ready`=1. Expect `wr_en`=1 for exactly one cycle with `mem_addr`=0x10 and `mem_wdata`=0xDEADBEEF, then `done`=1, `err`=0 on the next cycle.
- Read, 3 wait states: `addr`=0x20 with `mem_ready` low for 3 ACCESS cycles, then high with `mem_rdata`=0x12345678. Expect `rd_en` high for 4 cycles, then `done`=1 and `rdata`=0x12345678, held through a following write.
- Abort and range error:
  - `cs` drops during SETUP: expect a return to IDLE with no strobe and no `done`.
  - With `ADDR_MAX`=0x7F, request `addr`=0x80: expect `done`=1 and `err`=1 two cycles after acceptance, with `wr_en` and `rd_en` never asserted.
- Timeout, with `RWAC_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4:
  - `mem_ready` held low: expect `rd_en` for 4 cycles, then `done`=1, `err`=1.
  - `mem_ready` rising in ACCESS cycle 4: expect `err`=0.
- Reset mid-ACCESS: drop `reset_b` asynchronously while `wr_en`=1. Expect all outputs 0 immediately and `busy`=0. The first request after release completes normally.
- Back-to-back: `cs` held high continuously. Expect one access per 4 cycles, no request accepted during DONE, and strobes never overlapping.

Source files
------------

// File: rtl/rw_access_ctrl.sv
// rw_access_ctrl: sequences a single requester's chip-select request into a
// strobed access on a simple memory / register-file port.
// Flow: IDLE -> SETUP -> ACCESS (waits on mem_ready) -> DONE -> IDLE.
// Optional feature macro: RWAC_TIMEOUT_EN (bounds ACCESS to TIMEOUT_CYCLES
// cycles without mem_ready, then completes with err=1).
module rw_access_ctrl #(
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ADDR_MAX       = (2 ** ADDR_W) - 1,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              cs,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("rw_access_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_wr_flag;
    logic                r_err;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_busy;
    logic                r_done;
    logic                r_err_o;
    logic                r_wr_en;
    logic                r_rd_en;
    logic                w_addr_bad;

`ifdef RWAC_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]    r_wait_cnt;
    logic                w_timeout;

    // Last allowed ACCESS cycle without mem_ready has been reached.
    assign w_timeout = (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    // Address range check on the captured address.
    assign w_addr_bad = (32'(r_mem_addr) > ADDR_MAX);

    // Main sequencer: state, captured buses, read data and registered Moore outputs.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state     <= IDLE;
            r_wr_flag   <= 1'b0;
            r_err       <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err_o     <= 1'b0;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
`ifdef RWAC_TIMEOUT_EN
            r_wait_cnt  <= '0;
`endif
        end else begin
            // Pulse-type outputs default low; each branch sets the values
            // that belong to the state being entered.
            r_done  <= 1'b0;
            r_err_o <= 1'b0;
            r_wr_en <= 1'b0;
            r_rd_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cs) begin
                        r_wr_flag   <= write;
                        r_mem_addr  <= addr;
                        r_mem_wdata <= wdata;
                        r_err       <= 1'b0;
`ifdef RWAC_TIMEOUT_EN
                        r_wait_cnt  <= '0;
`endif
                        r_busy      <= 1'b1;
                        r_state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (!cs) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (w_addr_bad) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_err_o <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_wr_en <= r_wr_flag;
                        r_rd_en <= !r_wr_flag;
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        if (!r_wr_flag) begin
                            r_rdata <= mem_rdata;
                        end
                        r_done  <= 1'b1;
                        r_err_o <= r_err;
                        r_state <= DONE;
`ifdef RWAC_TIMEOUT_EN
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_err_o <= 1'b1;
                        r_state <= DONE;
`endif
                    end else begin
                        r_wr_en <= r_wr_flag;
                        r_rd_en <= !r_wr_flag;
`ifdef RWAC_TIMEOUT_EN
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
`endif
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err_o;
    assign rdata     = r_rdata;
    assign wr_en     = r_wr_en;
    assign rd_en     = r_rd_en;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_rw_access_ctrl.sv
// Scoreboard bench for rw_access_ctrl: the driver pushes the expected outcome
// of every request; a negedge monitor reconstructs each transaction from the
// DUT outputs and compares when busy falls.
module tb_rw_access_ctrl;

    localparam int unsigned AW   = 8;
    localparam int unsigned DW   = 32;
    localparam int unsigned AMAX = 'h7F;
    localparam int unsigned TMO  = 4;
`ifdef RWAC_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_b = 1'b0;
    logic          cs = 1'b0;
    logic          write = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic          busy, done, err, wr_en, rd_en;
    logic [DW-1:0] rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;

    rw_access_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .ADDR_MAX(AMAX), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset_b(reset_b), .cs(cs), .write(write), .addr(addr),
        .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
        .wr_en(wr_en), .rd_en(rd_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            abort;
        bit            err;
        int            strobes;
        int            busy_cycles;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t          sb_q[$];
    int            vectors = 0;
    int            miscompares = 0;
    logic [DW-1:0] model_rdata = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    int            m_busy, m_wr, m_rd, m_done;
    bit            m_prev_busy;
    logic          m_err;
    logic [DW-1:0] m_rdata, m_wdata;
    logic [AW-1:0] m_addr;

    task automatic m_clear();
        m_busy = 0; m_wr = 0; m_rd = 0; m_done = 0;
        m_err = 1'b0; m_rdata = '0; m_wdata = '0; m_addr = '0;
    endtask

    initial begin
        exp_t e;
        m_clear();
        m_prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_b) begin
                m_clear();
                m_prev_busy = 1'b0;
            end else begin
                if (wr_en && rd_en) chk("strobe_overlap", 1, 0);
                if (busy) begin
                    m_busy++;
                    if (wr_en) m_wr++;
                    if (rd_en) m_rd++;
                    if (done) begin
                        m_done++;
                        m_err = err; m_rdata = rdata; m_addr = mem_addr; m_wdata = mem_wdata;
                    end
                end else if (wr_en || rd_en || done) begin
                    chk("idle_outputs", {wr_en, rd_en, done}, 0);
                end
                if (m_prev_busy && !busy) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_txn", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("busy_cycles", m_busy, e.busy_cycles);
                        chk("wr_strobes", m_wr, e.wr ? e.strobes : 0);
                        chk("rd_strobes", m_rd, e.wr ? 0 : e.strobes);
                        chk("done_pulses", m_done, e.abort ? 0 : 1);
                        if (!e.abort) begin
                            chk("err", m_err, e.err);
                            chk("mem_addr", m_addr, e.addr);
                            chk("mem_wdata", m_wdata, e.wdata);
                            chk("rdata_at_done", m_rdata, e.rdata);
                        end
                        chk("rdata_held", rdata, e.rdata);
                    end
                    m_clear();
                end
                m_prev_busy = busy;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic idle(input int n);
        cs = 1'b0; mem_ready = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Called and returns at a negedge while the DUT is in IDLE.
    task automatic do_access(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input int nwait, input bit abort, input bit keep);
        exp_t          e;
        bit            aerr;
        logic [DW-1:0] rd_val;
        rd_val  = $urandom;
        aerr    = (a > AMAX);
        e.abort = abort; e.wr = wr; e.addr = a; e.wdata = d;
        if (abort) begin
            e.err = 0; e.strobes = 0; e.busy_cycles = 1;
        end else if (aerr) begin
            e.err = 1; e.strobes = 0; e.busy_cycles = 2;
        end else if (TMO_EN && nwait >= int'(TMO)) begin
            e.err = 1; e.strobes = TMO; e.busy_cycles = TMO + 2;
        end else begin
            e.err = 0; e.strobes = nwait + 1; e.busy_cycles = nwait + 3;
            if (!wr) model_rdata = rd_val;
        end
        e.rdata = model_rdata;
        sb_q.push_back(e);

        cs = 1'b1; write = wr; addr = a; wdata = d; mem_ready = 1'b0;
        @(posedge clk);                  // accepted
        @(negedge clk);                  // SETUP
        cs = abort ? 1'b0 : 1'b1;
        write = 1'($urandom); addr = AW'($urandom); wdata = $urandom;
        @(posedge clk);
        @(negedge clk);
        if (abort) return;
        for (int k = 0; k < e.strobes; k++) begin
            mem_ready = (k >= nwait);
            mem_rdata = mem_ready ? rd_val : DW'($urandom);
            cs = keep ? 1'b1 : 1'($urandom);
            @(posedge clk);
            @(negedge clk);
        end
        mem_ready = 1'b0;                // DONE
        cs = keep ? 1'b1 : 1'($urandom);
        @(posedge clk);
        @(negedge clk);                  // IDLE
    endtask

    initial begin
        int n;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_outs", {done, err, wr_en, rd_en}, 0);
        chk("rst_buses", {rdata, mem_addr, mem_wdata}, 0);
        @(negedge clk);
        reset_b = 1'b1;
        idle(2);

        do_access(1, 8'h10, 32'hDEADBEEF, 0, 0, 0);
        idle(1);
        do_access(0, 8'h20, 32'h0, 3, 0, 0);
        idle(1);
        do_access(1, 8'h21, 32'hCAFEF00D, 1, 0, 0);
        idle(1);
        do_access(1, 8'h30, 32'h11112222, 0, 1, 0);
        idle(1);
        do_access(1, 8'h80, 32'h33334444, 0, 0, 0);
        do_access(0, 8'hFF, 32'h0, 0, 0, 0);
        idle(1);
        do_access(0, 8'h7F, 32'h0, 2, 0, 0);
        do_access(0, 8'h40, 32'h0, 3, 0, 0);
        do_access(0, 8'h41, 32'h0, 5, 0, 0);
        idle(1);

        // Reset while a write strobe is high.
        cs = 1'b1; write = 1'b1; addr = 8'h50; wdata = 32'hA5A5A5A5; mem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #2;
        chk("pre_reset_wr_en", wr_en, 1);
        reset_b = 1'b0;
        #1;
        chk("async_rst_outs", {busy, done, err, wr_en, rd_en}, 0);
        chk("async_rst_buses", {rdata, mem_addr, mem_wdata}, 0);
        model_rdata = '0;
        cs = 1'b0;
        @(posedge clk);
        #2 reset_b = 1'b1;
        @(negedge clk);
        do_access(0, 8'h05, 32'h0, 0, 0, 0);

        // Back-to-back with cs held high throughout.
        for (int i = 0; i < 6; i++)
            do_access(1'(i), AW'(i * 3), DW'($urandom), 0, 0, 1);
        idle(2);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            n = $urandom_range(0, 6);
            do_access(1'($urandom), ($urandom_range(0, 3) == 0) ? AW'($urandom_range(AMAX + 1, 255))
                                                                : AW'($urandom_range(0, AMAX)),
                      DW'($urandom), n, ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        end

        idle(4);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
